// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader
//  Description : Writer side of the CPU instruction memory. Assembles 32-bit
//                instructions from pairs of 16-bit halfwords (high half first)
//                received on a valid/ready stream, writes them to sequential
//                inst_mem addresses and holds the CPU while a load is running.
//                A load ends after DEPTH words or after the Halt word is
//                written, whichever comes first.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
   parameter int         ADDR_W  = 4,
   parameter int         DEPTH   = 16,
   parameter logic [4:0] HALT_OP = 5'b11100
) (
   input  logic              clk,
   input  logic              sys_rest,
   input  logic              start,
   input  logic              din_valid,
   input  logic [15:0]       din,
   output logic              din_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_HI = 3'd1,
      S_LOAD_LO = 3'd2,
      S_WRITE   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [ADDR_W:0]     word_count_q, word_count_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                done_q, done_d;
   logic                is_halt;

   // The word being written terminates the load when it carries the Halt opcode.
   assign is_halt = (wr_data_q[31:27] == HALT_OP);

   // Next-state and next-output computation for the load sequencer.
   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      cpu_hold_d   = cpu_hold_q;
      done_d       = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // A reload from DONE behaves exactly like a first load from IDLE.
            if (start) begin
               state_d      = S_LOAD_HI;
               wr_addr_d    = '0;
               word_count_d = '0;
               done_d       = 1'b0;
               cpu_hold_d   = 1'b1;
            end
         end
         S_LOAD_HI: begin
            if (din_valid) begin
               wr_data_d[31:16] = din;
               state_d          = S_LOAD_LO;
            end
         end
         S_LOAD_LO: begin
            if (din_valid) begin
               wr_data_d[15:0] = din;
               state_d         = S_WRITE;
            end
         end
         S_WRITE: begin
            word_count_d = word_count_q + CNT_ONE;
            // Address never wraps: the last slot ends the load like a Halt does.
            if (is_halt || (wr_addr_q == LAST_ADDR)) begin
               state_d    = S_DONE;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else begin
               wr_addr_d = wr_addr_q + ADDR_ONE;
               state_d   = S_LOAD_HI;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; async reset leaves inst_mem contents untouched.
   always_ff @(posedge clk or posedge sys_rest) begin
      if (sys_rest) begin
         state_q      <= S_IDLE;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         word_count_q <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
      end
   end

   // Handshake and write strobe are pure decodes of the registered state.
   assign din_ready  = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
   assign wr_en      = (state_q == S_WRITE);
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_loader
//  Description : Self-checking bench for inst_mem_loader. Programs are kept as
//                word lists; a transaction-level model lists the writes each
//                program must produce, and a monitor collects the DUT writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_loader;

   localparam int         ADDR_W  = 4;
   localparam int         DEPTH   = 16;
   localparam logic [4:0] HALT_OP = 5'b11100;

   logic              clk = 1'b0;
   logic              sys_rest;
   logic              start;
   logic              din_valid;
   logic [15:0]       din;
   logic              din_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic [ADDR_W:0]   word_count;

   inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_OP(HALT_OP)) dut (
      .clk        (clk),
      .sys_rest   (sys_rest),
      .start      (start),
      .din_valid  (din_valid),
      .din        (din),
      .din_ready  (din_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;

   logic [31:0]       prog_q[$];
   logic [35:0]       exp_q[$];
   logic [35:0]       got_q[$];
   int unsigned       wr_cyc_q[$];

   typedef struct {
      logic [31:0] word;
      logic        exp_halt;
   } vec_t;
   vec_t vecs[6];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Collect every write; while writing the CPU must be held and the count
   // must equal the number of words already written in this load.
   always @(negedge clk) begin
      if (!sys_rest && wr_en) begin
         chk("hold_during_write", {62'd0, done, cpu_hold}, 64'd1);
         chk("count_during_write", 64'(word_count), 64'(got_q.size()));
         got_q.push_back({wr_addr, wr_data});
         wr_cyc_q.push_back(cyc);
      end
   end

   // Reference: words are written in order from address 0 until the Halt
   // word has been written or the memory is full.
   task automatic model_load();
      exp_q.delete();
      for (int i = 0; i < prog_q.size() && i < DEPTH; i++) begin
         exp_q.push_back({4'(i), prog_q[i]});
         if (prog_q[i][31:27] == HALT_OP) break;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one beat after an idle gap and hold it until it is accepted.
   task automatic send_beat(input logic [15:0] b, input int gap, input bit rnd);
      int g;
      bit taken;
      g = rnd ? int'($urandom_range(0, gap)) : gap;
      repeat (g) begin
         din_valid = 1'b0;
         din       = 16'hDEAD;
         @(posedge clk); #1;
      end
      din       = b;
      din_valid = 1'b1;
      taken     = 1'b0;
      for (int k = 0; k < 20 && !taken; k++) begin
         @(negedge clk);
         taken = din_ready;
         @(posedge clk); #1;
      end
      if (!taken) chk("beat_accept", 64'(din_ready), 64'd1);
   endtask

   task automatic send_words(input int first, input int n, input int gap, input bit rnd);
      for (int i = first; i < first + n; i++) begin
         send_beat(prog_q[i][31:16], gap, rnd);
         send_beat(prog_q[i][15:0], gap, rnd);
      end
      din_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic compare_writes(input string tag);
      chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
   endtask

   // Full load: start, stream the words the model says get consumed, check.
   task automatic run_load(input string tag, input int gap, input bit rnd, input bit spacing);
      model_load();
      got_q.delete();
      wr_cyc_q.delete();
      pulse_start();
      @(negedge clk);
      chk({tag, "_after_start"}, {61'd0, cpu_hold, done, din_ready}, 64'b101);
      @(posedge clk); #1;
      send_words(0, exp_q.size(), gap, rnd);
      wait_done();
      compare_writes(tag);
      chk({tag, "_word_count"}, 64'(word_count), 64'(exp_q.size()));
      chk({tag, "_cpu_hold_end"}, 64'(cpu_hold), 64'd0);
      if (spacing)
         for (int i = 1; i < wr_cyc_q.size(); i++)
            chk({tag, "_spacing"}, 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'd3);
   endtask

   task automatic load_prog1();
      prog_q.delete();
      for (int i = 0; i < 8; i++) prog_q.push_back(32'h08010005 + 32'(i));
      prog_q.push_back(32'hE0000000);
      prog_q.push_back(32'h08AA0000);
   endtask

   initial begin
      vecs[0] = '{32'hE0000000, 1'b1};
      vecs[1] = '{32'hE7FFFFFF, 1'b1};
      vecs[2] = '{32'hE8000000, 1'b0};
      vecs[3] = '{32'hD8000000, 1'b0};
      vecs[4] = '{32'hF8000000, 1'b0};
      vecs[5] = '{32'h08010005, 1'b0};

      sys_rest  = 1'b1;
      start     = 1'b0;
      din_valid = 1'b0;
      din       = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {din_ready, wr_en, wr_addr, wr_data, cpu_hold, done, word_count}, 64'd0);
      sys_rest = 1'b0;
      @(posedge clk); #1;

      // Test 1 / 6: halt-terminated program, valid held high, including during WRITE.
      load_prog1();
      run_load("t1", 0, 1'b0, 1'b1);

      // Test 2: sixteen non-halt words fill the memory; further beats refused.
      prog_q.delete();
      for (int i = 0; i < 17; i++) prog_q.push_back({5'b00010, 27'(i * 7 + 1)});
      run_load("t2", 0, 1'b0, 1'b1);
      din_valid = 1'b1;
      din       = 16'h1234;
      repeat (3) begin
         @(negedge clk);
         chk("t2_ready_after_full", 64'(din_ready), 64'd0);
      end
      din_valid = 1'b0;
      chk("t2_no_extra_write", 64'(got_q.size()), 64'd16);
      @(posedge clk); #1;

      // Test 3: same program as test 1 with two idle cycles before every beat.
      load_prog1();
      run_load("t3", 2, 1'b0, 1'b0);

      // Halt-opcode boundary table: one word per load.
      foreach (vecs[v]) begin
         got_q.delete();
         pulse_start();
         prog_q.delete();
         prog_q.push_back(vecs[v].word);
         send_words(0, 1, 0, 1'b0);
         @(negedge clk);
         chk("vec_write", {27'd0, wr_en, wr_addr, wr_data}, {27'd0, 1'b1, 4'd0, vecs[v].word});
         @(negedge clk);
         chk("vec_status", {60'd0, done, cpu_hold, 2'b00} | 64'(word_count == 5'd1),
             {60'd0, vecs[v].exp_halt, ~vecs[v].exp_halt, 2'b00} | 64'd1);
         if (!vecs[v].exp_halt) begin
            @(posedge clk); #1;
            prog_q[0] = 32'hE0000000;
            send_words(0, 1, 0, 1'b0);
            wait_done();
            chk("vec_count2", 64'(word_count), 64'd2);
         end
      end
      @(posedge clk); #1;

      // Test 4: asynchronous reset in LOAD_LO after three words written.
      load_prog1();
      got_q.delete();
      pulse_start();
      send_words(0, 3, 0, 1'b0);
      send_beat(prog_q[3][31:16], 0, 1'b0);
      din_valid = 1'b0;
      chk("t4_pre_reset", {59'd0, din_ready, cpu_hold, word_count[2:0]}, {59'd0, 2'b11, 3'd3});
      chk("t4_pre_writes", 64'(got_q.size()), 64'd3);
      #2 sys_rest = 1'b1;
      #1;
      chk("t4_async_reset", {din_ready, wr_en, wr_addr, wr_data, cpu_hold, done, word_count}, 64'd0);
      @(posedge clk); #1;
      sys_rest = 1'b0;
      @(posedge clk); #1;
      run_load("t4_reload", 0, 1'b0, 1'b0);

      // Test 5: start ignored in LOAD_HI; start in DONE reloads from address 0.
      prog_q.delete();
      prog_q.push_back(32'h01111111);
      prog_q.push_back(32'h02222222);
      prog_q.push_back(32'h03333333);
      prog_q.push_back(32'hE1234567);
      model_load();
      got_q.delete();
      pulse_start();
      send_words(0, 1, 0, 1'b0);
      @(posedge clk); #1;
      pulse_start();
      @(negedge clk);
      chk("t5_start_ignored", {59'd0, din_ready, done, wr_addr}, {59'd0, 2'b10, 4'd1});
      @(posedge clk); #1;
      send_words(1, 3, 0, 1'b0);
      wait_done();
      compare_writes("t5");
      got_q.delete();
      pulse_start();
      @(negedge clk);
      chk("t5_restart", {58'd0, done, cpu_hold, 4'd0} | 64'(word_count), {58'd0, 2'b01, 4'd0});
      @(posedge clk); #1;
      prog_q.delete();
      prog_q.push_back(32'hE0000000);
      model_load();
      send_words(0, 1, 0, 1'b0);
      wait_done();
      compare_writes("t5_reload");

      // Randomised programs with random idle gaps between beats.
      for (int r = 0; r < 8; r++) begin
         prog_q.delete();
         for (int i = 0; i < 20; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 5) == 0) w[31:27] = HALT_OP;
            else if (w[31:27] == HALT_OP) w[27] = ~w[27];
            prog_q.push_back(w);
         end
         run_load("rand", 2, 1'b1, 1'b0);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
